aes_cmd_framer: RTL

- Transmit-side counterpart of the AES controller input stage. Builds the command stream the controller consumes: command block, key block(s), optional IV block, then N data blocks.
- Serializes each 128-bit block into BUS_DATA_WIDTH-bit AXI-Stream beats and asserts tlast on the final beat of the final data block.
- Used by bench/loopback drivers and the on-chip self-test path to feed aes_controller.

---
 rtl/aes_cmd_framer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/aes_cmd_framer.sv
// rtl/aes_cmd_framer.sv - builds the AES controller command stream and serializes it into AXI-Stream beats
module aes_cmd_framer #(
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BLK_S          = 128,
    parameter int FRAME_CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [31:0]               cfg_cmd,
    input  logic [255:0]              cfg_key,
    input  logic                      cfg_key256,
    input  logic                      cfg_need_iv,
    input  logic [BLK_S-1:0]          cfg_iv,
    input  logic                      blk_tvalid,
    output logic                      blk_tready,
    input  logic [BLK_S-1:0]          blk_tdata,
    input  logic                      blk_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic [BUS_DATA_WIDTH-1:0] m_tdata,
    output logic                      m_tlast,
    output logic                      busy,
    output logic [FRAME_CNT_W-1:0]    frames_sent
);

    localparam int BPB   = BLK_S / BUS_DATA_WIDTH;
    localparam int CNT_W = (BPB > 1) ? $clog2(BPB) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BPB - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        KEY_LO,
        KEY_HI,
        IV,
        DATA,
        WAIT_BLK
    } state_t;

    state_t           state;
    logic [BLK_S-1:0] blk_reg;
    logic [CNT_W-1:0] beat_cnt;
    logic [255:0]     key_q;
    logic [BLK_S-1:0] iv_q;
    logic             key256_q;
    logic             need_iv_q;
    logic             last_q;

    logic             hs;
    logic             last_beat;
    logic [CNT_W-1:0] nxt_cnt;

    // The outgoing beat is always the top slice of the block register; it shifts left after each beat.
    assign m_tdata   = blk_reg[BLK_S-1 -: BUS_DATA_WIDTH];
    assign hs        = m_tvalid && m_tready;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign nxt_cnt   = beat_cnt + CNT_W'(1);

    // Accept a block while waiting, or in the same cycle the final beat of a non-last block leaves,
    // so consecutive data blocks stream without a bubble.
    assign blk_tready = (state == WAIT_BLK) ||
                        ((state == DATA) && m_tvalid && m_tready && last_beat && !last_q);

    // Frame sequencer: header blocks from latched config, then data blocks until the flagged last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            blk_reg     <= '0;
            beat_cnt    <= '0;
            key_q       <= '0;
            iv_q        <= '0;
            key256_q    <= 1'b0;
            need_iv_q   <= 1'b0;
            last_q      <= 1'b0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            busy        <= 1'b0;
            frames_sent <= '0;
        end else if (hs) begin
            if (!last_beat) begin
                blk_reg  <= blk_reg << BUS_DATA_WIDTH;
                beat_cnt <= nxt_cnt;
                m_tlast  <= (state == DATA) && last_q && (nxt_cnt == LAST_BEAT);
            end else begin
                beat_cnt <= '0;
                case (state)
                    CMD: begin
                        state   <= KEY_LO;
                        blk_reg <= key_q[127:0];
                    end
                    KEY_LO: begin
                        if (key256_q) begin
                            state   <= KEY_HI;
                            blk_reg <= key_q[255:128];
                        end else if (need_iv_q) begin
                            state   <= IV;
                            blk_reg <= iv_q;
                        end else begin
                            state    <= WAIT_BLK;
                            m_tvalid <= 1'b0;
                        end
                    end
                    KEY_HI: begin
                        if (need_iv_q) begin
                            state   <= IV;
                            blk_reg <= iv_q;
                        end else begin
                            state    <= WAIT_BLK;
                            m_tvalid <= 1'b0;
                        end
                    end
                    IV: begin
                        state    <= WAIT_BLK;
                        m_tvalid <= 1'b0;
                    end
                    DATA: begin
                        if (last_q) begin
                            state       <= IDLE;
                            m_tvalid    <= 1'b0;
                            m_tlast     <= 1'b0;
                            busy        <= 1'b0;
                            frames_sent <= frames_sent + FRAME_CNT_W'(1);
                        end else if (blk_tvalid) begin
                            blk_reg <= blk_tdata;
                            last_q  <= blk_tlast;
                            m_tlast <= blk_tlast && (BPB == 1);
                        end else begin
                            state    <= WAIT_BLK;
                            m_tvalid <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        m_tvalid <= 1'b0;
                    end
                endcase
            end
        end else if ((state == IDLE) && start) begin
            state     <= CMD;
            blk_reg   <= BLK_S'(cfg_cmd);
            beat_cnt  <= '0;
            key_q     <= cfg_key;
            iv_q      <= cfg_iv;
            key256_q  <= cfg_key256;
            need_iv_q <= cfg_need_iv;
            m_tvalid  <= 1'b1;
            m_tlast   <= 1'b0;
            busy      <= 1'b1;
        end else if ((state == WAIT_BLK) && blk_tvalid) begin
            state    <= DATA;
            blk_reg  <= blk_tdata;
            last_q   <= blk_tlast;
            beat_cnt <= '0;
            m_tvalid <= 1'b1;
            m_tlast  <= blk_tlast && (BPB == 1);
        end
    end

endmodule
